// File: rtl/vthernet_rx_udp_parser.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : vthernet_rx_udp_parser                                        |
// | Purpose  : GMII receive parser. Strips preamble/SFD, filters Ethernet II,|
// |            IPv4 (no options) and UDP headers against the configured      |
// |            station addresses, and streams the UDP payload into the rx    |
// |            payload SRAM write port starting at address 0 per frame.      |
// | Ports    : RX_CLK/rst        - GMII rx clock, async active-low reset     |
// |            RX_DV/RXD/RX_ER   - GMII receive interface                    |
// |            rx_udp_data_vb    - active-low SRAM write strobe              |
// |            rx_udp_data/addr  - SRAM write data / address                 |
// |            rx_udp_len        - payload byte count of last datagram       |
// |            rx_irq            - one-cycle datagram-complete pulse         |
// |            rx_drop_cnt       - saturating rejected/aborted frame count   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vthernet_rx_udp_parser #(
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] IP_ADDR   = 32'hC0A8_0164,
  parameter logic [15:0] UDP_PORT  = 16'd1234,
  parameter int          MEM_DEPTH = 1024,
  localparam int         AW        = $clog2(MEM_DEPTH)
) (
  input  logic          RX_CLK,
  input  logic          rst,
  input  logic          RX_DV,
  input  logic [7:0]    RXD,
  input  logic          RX_ER,
  output logic          rx_udp_data_vb,
  output logic [7:0]    rx_udp_data,
  output logic [AW-1:0] rx_addr,
  output logic [15:0]   rx_udp_len,
  output logic          rx_irq,
  output logic [7:0]    rx_drop_cnt
);

  localparam logic [AW:0] DEPTH = (AW+1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_HEADER   = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_DONE     = 3'd4,
    S_DISCARD  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    hdr_cnt_q, hdr_cnt_d;
  logic          uc_ok_q, uc_ok_d;      // dst MAC still matches station address
  logic          bc_ok_q, bc_ok_d;      // dst MAC still matches broadcast
  logic [15:0]   len_q, len_d;          // latched UDP length field
  logic [15:0]   rem_q, rem_d;          // payload bytes still to consume
  logic [AW:0]   wr_cnt_q, wr_cnt_d;    // payload bytes written this frame
  logic          irq_pend_q, irq_pend_d;
  logic          vb_q, vb_d;
  logic [7:0]    data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   ulen_q, ulen_d;
  logic          irq_q, irq_d;
  logic [7:0]    drop_q, drop_d;

  logic          drop_inc;
  logic          hdr_bad;
  logic          hdr_chk;
  logic [7:0]    hdr_exp;
  logic [7:0]    mac_byte;
  logic          uc_hit;
  logic          bc_hit;
  logic [15:0]   len_full;

  // Fixed-value header bytes that must match exactly.
  always_comb begin
    hdr_chk = 1'b0;
    hdr_exp = 8'h00;
    case (hdr_cnt_q)
      6'd12: begin hdr_chk = 1'b1; hdr_exp = 8'h08;            end
      6'd13: begin hdr_chk = 1'b1; hdr_exp = 8'h00;            end
      6'd14: begin hdr_chk = 1'b1; hdr_exp = 8'h45;            end
      6'd23: begin hdr_chk = 1'b1; hdr_exp = 8'h11;            end
      6'd30: begin hdr_chk = 1'b1; hdr_exp = IP_ADDR[31:24];   end
      6'd31: begin hdr_chk = 1'b1; hdr_exp = IP_ADDR[23:16];   end
      6'd32: begin hdr_chk = 1'b1; hdr_exp = IP_ADDR[15:8];    end
      6'd33: begin hdr_chk = 1'b1; hdr_exp = IP_ADDR[7:0];     end
      6'd36: begin hdr_chk = 1'b1; hdr_exp = UDP_PORT[15:8];   end
      6'd37: begin hdr_chk = 1'b1; hdr_exp = UDP_PORT[7:0];    end
      default: ;
    endcase
  end

  always_comb begin
    mac_byte = MAC_ADDR[47:40];
    case (hdr_cnt_q)
      6'd1:    mac_byte = MAC_ADDR[39:32];
      6'd2:    mac_byte = MAC_ADDR[31:24];
      6'd3:    mac_byte = MAC_ADDR[23:16];
      6'd4:    mac_byte = MAC_ADDR[15:8];
      6'd5:    mac_byte = MAC_ADDR[7:0];
      default: mac_byte = MAC_ADDR[47:40];
    endcase
  end

  // Unicast and broadcast candidates are tracked independently so a frame
  // mixing bytes of both addresses is rejected.
  assign uc_hit   = uc_ok_q && (RXD == mac_byte);
  assign bc_hit   = bc_ok_q && (RXD == 8'hFF);
  assign len_full = {len_q[15:8], RXD};

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    uc_ok_d    = uc_ok_q;
    bc_ok_d    = bc_ok_q;
    len_d      = len_q;
    rem_d      = rem_q;
    wr_cnt_d   = wr_cnt_q;
    irq_pend_d = 1'b0;
    vb_d       = 1'b1;
    data_d     = data_q;
    addr_d     = addr_q;
    ulen_d     = ulen_q;
    irq_d      = irq_pend_q;
    drop_inc   = 1'b0;
    hdr_bad    = 1'b0;

    // Length is published together with the irq pulse.
    if (irq_pend_q) begin
      ulen_d = 16'(wr_cnt_q);
    end

    case (state_q)
      S_IDLE: begin
        if (RX_DV) begin
          state_d = (RXD == 8'h55) ? S_PREAMBLE : S_DISCARD;
        end
      end

      S_PREAMBLE: begin
        if (!RX_DV) begin
          state_d = S_IDLE;
        end else if (RX_ER) begin
          state_d  = S_DISCARD;
          drop_inc = 1'b1;
        end else if (RXD == 8'hD5) begin
          state_d   = S_HEADER;
          hdr_cnt_d = 6'd0;
          uc_ok_d   = 1'b1;
          bc_ok_d   = 1'b1;
        end else if (RXD != 8'h55) begin
          state_d  = S_DISCARD;
          drop_inc = 1'b1;
        end
      end

      S_HEADER: begin
        if (!RX_DV) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end else if (RX_ER) begin
          state_d  = S_DISCARD;
          drop_inc = 1'b1;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q < 6'd6) begin
            uc_ok_d = uc_hit;
            bc_ok_d = bc_hit;
            hdr_bad = !(uc_hit || bc_hit);
          end
          if (hdr_chk && (RXD != hdr_exp)) begin
            hdr_bad = 1'b1;
          end
          if (hdr_cnt_q == 6'd38) begin
            len_d[15:8] = RXD;
          end
          if (hdr_cnt_q == 6'd39) begin
            len_d[7:0] = RXD;
            if (len_full < 16'd8) begin
              hdr_bad = 1'b1;
            end
          end

          if (hdr_bad) begin
            state_d  = S_DISCARD;
            drop_inc = 1'b1;
          end else if (hdr_cnt_q == 6'd41) begin
            rem_d    = len_q - 16'd8;
            wr_cnt_d = '0;
            addr_d   = '0;
            if (len_q == 16'd8) begin
              state_d    = S_DONE;
              irq_pend_d = 1'b1;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (!RX_DV) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end else if (RX_ER) begin
          state_d  = S_DISCARD;
          drop_inc = 1'b1;
        end else begin
          // Bytes beyond the buffer are consumed but never written.
          if (wr_cnt_q < DEPTH) begin
            vb_d     = 1'b0;
            data_d   = RXD;
            addr_d   = wr_cnt_q[AW-1:0];
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d    = S_DONE;
            irq_pend_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (!RX_DV) begin
          state_d = S_IDLE;
        end
      end

      S_DISCARD: begin
        if (!RX_DV) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    drop_d = drop_q;
    if (drop_inc && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= '0;
      uc_ok_q    <= 1'b0;
      bc_ok_q    <= 1'b0;
      len_q      <= '0;
      rem_q      <= '0;
      wr_cnt_q   <= '0;
      irq_pend_q <= 1'b0;
      vb_q       <= 1'b1;
      data_q     <= '0;
      addr_q     <= '0;
      ulen_q     <= '0;
      irq_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      uc_ok_q    <= uc_ok_d;
      bc_ok_q    <= bc_ok_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      wr_cnt_q   <= wr_cnt_d;
      irq_pend_q <= irq_pend_d;
      vb_q       <= vb_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      ulen_q     <= ulen_d;
      irq_q      <= irq_d;
      drop_q     <= drop_d;
    end
  end

  assign rx_udp_data_vb = vb_q;
  assign rx_udp_data    = data_q;
  assign rx_addr        = addr_q;
  assign rx_udp_len     = ulen_q;
  assign rx_irq         = irq_q;
  assign rx_drop_cnt    = drop_q;

endmodule
`default_nettype wire
